// File: rtl/mstr_stream_tx.sv
// mstr_stream_tx: drains processed BMP words from the output FIFO onto a valid/ready master stream,
// sizing the transfer from the BMP header. MSTR_TX_TIMEOUT_EN builds the FIFO-starvation abort.
module mstr_stream_tx #(
  parameter int unsigned D_WIDTH        = 32,
  parameter int unsigned HEADER_SIZE    = 14,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_empty,
  output logic               fifo_rd,
  input  logic [D_WIDTH-1:0] fifo_data,
  output logic [D_WIDTH-1:0] mstr_data,
  output logic               mstr_valid,
  input  logic               mstr_ready,
  output logic               mstr_last,
  output logic               mstr_data_cmplt,
  output logic               size_err,
  output logic               timeout_err
);

  localparam int unsigned HDR_BEATS = (D_WIDTH == 64) ? 1 : 2;
  localparam int unsigned CNT_W     = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_XFER  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state, state_nxt;
  logic [D_WIDTH-1:0] buf_head, buf_tail;
  logic [1:0]         buf_cnt;
  logic               inflight;
  logic [CNT_W-1:0]   reqd, sent, total;
  logic               size_known, got_first;
  logic               size_err_q, timeout_err_q, cmplt_q;

  logic               pop, start, decode_now, timeout_hit, last_pop;
  logic [CNT_W-1:0]   limit;
  logic [2:0]         occ;
  logic [31:0]        hdr_size;
  logic [CNT_W-1:0]   lanes, lanes_eff, total_new;
  logic               lanes_short;

  assign pop   = mstr_valid && mstr_ready;
  assign start = (state == S_IDLE) && !fifo_empty;
  assign limit = size_known ? total : CNT_W'(HDR_BEATS);
  assign occ   = 3'(buf_cnt) + 3'(inflight) - 3'(pop);

  // Never request more than the 2-entry buffer can hold once in-flight data lands.
  assign fifo_rd = (state == S_XFER) && !fifo_empty && (reqd < limit) && (occ < 3'd2) && !timeout_hit;

  // Size field is bytes 2..5; in 32-bit mode the low half arrives one beat earlier.
  if (D_WIDTH == 64) begin : g_hdr64
    assign hdr_size = {fifo_data[47:32], fifo_data[31:16]};
  end else begin : g_hdr32
    logic [15:0] w0_hi;
    always_ff @(posedge clk) begin
      if (rst)
        w0_hi <= '0;
      else if (inflight && !size_known && !got_first)
        w0_hi <= fifo_data[31:16];
    end
    assign hdr_size = {fifo_data[15:0], w0_hi};
  end

  assign lanes       = CNT_W'(hdr_size[31:2]) + CNT_W'(|hdr_size[1:0]);
  assign lanes_short = lanes < CNT_W'(HEADER_SIZE);
  assign lanes_eff   = lanes_short ? CNT_W'(HEADER_SIZE) : lanes;
  assign total_new   = (D_WIDTH == 64) ? ((lanes_eff + CNT_W'(1)) >> 1) : lanes_eff;
  assign decode_now  = inflight && !size_known && ((D_WIDTH == 64) || got_first);

`ifdef MSTR_TX_TIMEOUT_EN
  logic [CNT_W-1:0] starve_cnt;
  always_ff @(posedge clk) begin
    if (rst || (state != S_XFER) || fifo_rd)
      starve_cnt <= '0;
    else if (fifo_empty && (reqd < limit))
      starve_cnt <= starve_cnt + CNT_W'(1);
  end
  assign timeout_hit = (state == S_XFER) && (starve_cnt >= CNT_W'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  assign mstr_valid      = (buf_cnt != 2'd0);
  assign mstr_data       = buf_head;
  assign mstr_last       = mstr_valid && (sent == total - CNT_W'(1));
  assign last_pop        = pop && mstr_last;
  assign mstr_data_cmplt = cmplt_q;
  assign size_err        = size_err_q;
`ifdef MSTR_TX_TIMEOUT_EN
  assign timeout_err     = timeout_err_q;
`else
  assign timeout_err     = 1'b0;
`endif

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!fifo_empty) state_nxt = S_XFER;
      S_XFER: begin
        if (timeout_hit)
          state_nxt = S_DONE;
        else if (size_known && (reqd == total))
          state_nxt = S_DRAIN;
      end
      S_DRAIN: if (last_pop) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cmplt_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cmplt_q <= (state_nxt == S_DONE);
    end
  end

  // Transfer bookkeeping: request/send counters and header decode
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight      <= 1'b0;
      reqd          <= '0;
      sent          <= '0;
      total         <= '0;
      size_known    <= 1'b0;
      got_first     <= 1'b0;
      size_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      inflight <= fifo_rd;
      if (start) begin
        reqd          <= '0;
        sent          <= '0;
        total         <= '0;
        size_known    <= 1'b0;
        got_first     <= 1'b0;
        size_err_q    <= 1'b0;
        timeout_err_q <= 1'b0;
      end else begin
        if (fifo_rd) reqd <= reqd + CNT_W'(1);
        if (pop)     sent <= sent + CNT_W'(1);
        if (decode_now) begin
          total      <= total_new;
          size_known <= 1'b1;
          size_err_q <= lanes_short;
        end else if (inflight && !size_known) begin
          got_first  <= 1'b1;
        end
        if (timeout_hit) timeout_err_q <= 1'b1;
      end
    end
  end

  // Two-entry output buffer; head drives the stream directly
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_head <= '0;
      buf_tail <= '0;
      buf_cnt  <= '0;
    end else if (timeout_hit) begin
      buf_cnt  <= '0;
    end else begin
      case ({inflight, pop})
        2'b01: begin
          buf_head <= buf_tail;
          buf_cnt  <= buf_cnt - 2'd1;
        end
        2'b10: begin
          if (buf_cnt == 2'd0) buf_head <= fifo_data;
          else                 buf_tail <= fifo_data;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf_head <= fifo_data;
          end else begin
            buf_head <= buf_tail;
            buf_tail <= fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mstr_stream_tx.sv
// Bench for mstr_stream_tx: 32- and 64-bit instances fed from FIFO models, checked by an
// expected-beat scoreboard plus a vector table; MSTR_TX_TIMEOUT_EN adds the starvation case.
module tb_mstr_stream_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ready;
  logic        a_empty, a_rd, a_valid, a_last, a_cmplt, a_serr, a_terr;
  logic [31:0] a_fdata, a_data;
  logic        b_empty, b_rd, b_valid, b_last, b_cmplt, b_serr, b_terr;
  logic [63:0] b_fdata, b_data;

  logic        hold_a, hold_b, clr_a, clr_b;
  logic [31:0] mem_a [64];
  logic [63:0] mem_b [64];
  logic [5:0]  rp_a, wp_a, rp_b, wp_b;

  mstr_stream_tx #(.D_WIDTH(32), .HEADER_SIZE(14), .TIMEOUT_CYCLES(16)) u_a (
    .clk(clk), .rst(rst), .fifo_empty(a_empty), .fifo_rd(a_rd), .fifo_data(a_fdata),
    .mstr_data(a_data), .mstr_valid(a_valid), .mstr_ready(ready), .mstr_last(a_last),
    .mstr_data_cmplt(a_cmplt), .size_err(a_serr), .timeout_err(a_terr));

  mstr_stream_tx #(.D_WIDTH(64), .HEADER_SIZE(14), .TIMEOUT_CYCLES(16)) u_b (
    .clk(clk), .rst(rst), .fifo_empty(b_empty), .fifo_rd(b_rd), .fifo_data(b_fdata),
    .mstr_data(b_data), .mstr_valid(b_valid), .mstr_ready(ready), .mstr_last(b_last),
    .mstr_data_cmplt(b_cmplt), .size_err(b_serr), .timeout_err(b_terr));

  // FIFO models: read data appears the cycle after the strobe
  assign a_empty = hold_a || (rp_a == wp_a);
  assign b_empty = hold_b || (rp_b == wp_b);
  always @(posedge clk) begin
    if (clr_a) rp_a <= '0;
    else if (a_rd) begin a_fdata <= mem_a[rp_a]; rp_a <= rp_a + 6'd1; end
  end
  always @(posedge clk) begin
    if (clr_b) rp_b <= '0;
    else if (b_rd) begin b_fdata <= mem_b[rp_b]; rp_b <= rp_b + 6'd1; end
  end

  typedef struct { logic [63:0] data; logic last; } beat_t;
  typedef struct { int sel; logic [31:0] size; bit toggle; int beats; bit serr; } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[8];

  int n_cmp = 0, n_err = 0, cyc = 0;
  int n_beats, n_last, n_cmplt, n_rd, first_rd, first_v, lastpop_k, cmplt_k;
  logic prev_stall;
  logic s_valid, s_last, s_cmplt, s_rd, s_serr, s_terr;
  logic [63:0] s_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic get_outs(input int sel);
    if (sel == 0) begin
      s_valid = a_valid; s_data = 64'(a_data); s_last = a_last; s_cmplt = a_cmplt;
      s_rd = a_rd; s_serr = a_serr; s_terr = a_terr;
    end else begin
      s_valid = b_valid; s_data = b_data; s_last = b_last; s_cmplt = b_cmplt;
      s_rd = b_rd; s_serr = b_serr; s_terr = b_terr;
    end
  endtask

  function automatic logic [31:0] lane(input logic [31:0] size, input int i);
    if (i == 0)      return {size[15:0], 16'h4D42};
    else if (i == 1) return {16'($urandom), size[31:16]};
    else             return $urandom;
  endfunction

  // Fill the FIFO model with an image and queue the beats the stream must produce
  task automatic load_image(input int sel, input logic [31:0] size, input int nbeats, input bit mark_last);
    beat_t e;
    logic [31:0] lo, hi;
    if (sel == 0) begin hold_a = 1'b1; clr_a = 1'b1; end
    else          begin hold_b = 1'b1; clr_b = 1'b1; end
    tick();
    clr_a = 1'b0; clr_b = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (sel == 0) begin
        lo = lane(size, b);
        mem_a[b] = lo;
        e.data = {32'h0, lo};
      end else begin
        lo = lane(size, 2 * b);
        hi = lane(size, 2 * b + 1);
        mem_b[b] = {hi, lo};
        e.data = {hi, lo};
      end
      e.last = mark_last && (b == nbeats - 1);
      exp_q.push_back(e);
    end
    if (sel == 0) wp_a = 6'(nbeats); else wp_b = 6'(nbeats);
  endtask

  task automatic sample(input int sel, input int k);
    beat_t e;
    get_outs(sel);
    if (prev_stall) check("valid_held", 64'(s_valid), 64'd1);
    if (s_rd) begin n_rd++; if (first_rd < 0) first_rd = k; end
    if (s_valid && first_v < 0) first_v = k;
    if (s_cmplt) begin n_cmplt++; if (cmplt_k < 0) cmplt_k = k; end
    if (s_valid) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 64'(s_valid), 64'd0);
      end else begin
        e = exp_q[0];
        check("beat_data", s_data, e.data);
        check("beat_last", 64'(s_last), 64'(e.last));
        if (ready) begin
          void'(exp_q.pop_front());
          n_beats++;
          if (s_last) begin n_last++; lastpop_k = k; end
        end
      end
    end
    prev_stall = s_valid && !ready;
  endtask

  // Release the FIFO and clock until completion (plus a short tail) or a pop count
  task automatic run(input int sel, input bit toggle, input int max_cyc, input int stop_pops);
    int tail;
    n_beats = 0; n_last = 0; n_cmplt = 0; n_rd = 0; first_rd = -1; first_v = -1;
    lastpop_k = -100; cmplt_k = -1; prev_stall = 1'b0; tail = -1;
    tick();
    if (sel == 0) hold_a = 1'b0; else hold_b = 1'b0;
    ready = 1'b1;
    #1; sample(sel, 0);
    for (int k = 1; k < max_cyc; k++) begin
      tick();
      ready = toggle ? ~ready : 1'b1;
      #1; sample(sel, k);
      if (stop_pops >= 0 && n_beats >= stop_pops) return;
      if (n_cmplt > 0 && tail < 0) tail = 3;
      else if (tail > 0) tail--;
      if (tail == 0) return;
    end
    check("completion_within_budget", 64'(n_cmplt > 0), 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    load_image(v.sel, v.size, v.beats, 1'b1);
    run(v.sel, v.toggle, 400, -1);
    check("beats",        64'(n_beats), 64'(v.beats));
    check("fifo_reads",   64'(n_rd), 64'(v.beats));
    check("last_count",   64'(n_last), 64'd1);
    check("cmplt_count",  64'(n_cmplt), 64'd1);
    check("first_rd_cyc", 64'(first_rd), 64'd1);
    check("first_v_cyc",  64'(first_v), 64'd3);
    check("cmplt_gap",    64'(cmplt_k - lastpop_k), 64'd1);
    check("size_err",     64'(s_serr), 64'(v.serr));
    check("timeout_err",  64'(s_terr), 64'd0);
    check("valid_idle",   64'(s_valid), 64'd0);
    check("sb_empty",     64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    vecs[0] = '{0, 32'h40, 1'b0, 16, 1'b0};
    vecs[1] = '{0, 32'h40, 1'b1, 16, 1'b0};
    vecs[2] = '{0, 32'h36, 1'b0, 14, 1'b0};
    vecs[3] = '{0, 32'h20, 1'b1, 14, 1'b1};
    vecs[4] = '{0, 32'h41, 1'b0, 17, 1'b0};
    vecs[5] = '{1, 32'h45, 1'b0,  9, 1'b0};
    vecs[6] = '{1, 32'h45, 1'b1,  9, 1'b0};
    vecs[7] = '{1, 32'h10, 1'b0,  7, 1'b1};

    rst = 1'b1; ready = 1'b1; hold_a = 1'b1; hold_b = 1'b1; clr_a = 1'b1; clr_b = 1'b1;
    wp_a = '0; wp_b = '0;
    repeat (3) tick();
    clr_a = 1'b0; clr_b = 1'b0;
    #1;
    get_outs(0);
    check("rst_fifo_rd", 64'(s_rd), 64'd0);
    check("rst_data",    s_data, 64'd0);
    check("rst_valid",   64'(s_valid), 64'd0);
    check("rst_last",    64'(s_last), 64'd0);
    check("rst_cmplt",   64'(s_cmplt), 64'd0);
    check("rst_size_err", 64'(s_serr), 64'd0);
    check("rst_timeout_err", 64'(s_terr), 64'd0);
    get_outs(1);
    check("rst_valid_64", 64'(s_valid), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

`ifdef MSTR_TX_TIMEOUT_EN
    // Starvation after four beats: abort with a completion pulse and no last beat
    load_image(0, 32'h40, 4, 1'b0);
    run(0, 1'b0, 200, -1);
    check("tmo_beats",  64'(n_beats), 64'd4);
    check("tmo_last",   64'(n_last), 64'd0);
    check("tmo_cmplt",  64'(n_cmplt), 64'd1);
    check("tmo_err",    64'(s_terr), 64'd1);
    check("tmo_valid",  64'(s_valid), 64'd0);
    check("tmo_sb",     64'(exp_q.size()), 64'd0);
`endif

    // Reset while beat 5 is on the bus, then a clean image
    load_image(0, 32'h40, 16, 1'b1);
    run(0, 1'b0, 400, 4);
    check("pre_rst_beats", 64'(n_beats), 64'd4);
    tick();
    rst = 1'b1; hold_a = 1'b1;
    tick();
    #1;
    get_outs(0);
    check("mid_rst_fifo_rd", 64'(s_rd), 64'd0);
    check("mid_rst_data",    s_data, 64'd0);
    check("mid_rst_valid",   64'(s_valid), 64'd0);
    check("mid_rst_last",    64'(s_last), 64'd0);
    check("mid_rst_cmplt",   64'(s_cmplt), 64'd0);
    check("mid_rst_size_err", 64'(s_serr), 64'd0);
    check("mid_rst_timeout_err", 64'(s_terr), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
